// File: rtl/vcap_line_writer.sv
// Drains one captured line from the ram-clock line FIFO into the frame buffer in request/grant bursts.
// Builds {buffer, line, column} addresses, swaps frame buffers and flags out-of-sequence lines.
module vcap_line_writer #(
    parameter int SCR_SIZE_BIT = 11,
    parameter int BURST_LEN    = 8,
    parameter int COL_BITS     = 10,
    parameter int LINE_BITS    = 9
) (
    input  logic                              i_ram_clk,
    input  logic                              i_reset,
    input  logic                              i_fifo_active,
    input  logic [LINE_BITS-1:0]              i_fifo_line,
    input  logic [11:0]                       i_fifo_data,
    output logic                              o_fifo_next,
    output logic                              o_fifo_reset,
    input  logic [SCR_SIZE_BIT:0]             i_x_size,
    input  logic [SCR_SIZE_BIT:0]             i_y_size,
    output logic                              o_wr_req,
    input  logic                              i_wr_gnt,
    output logic [LINE_BITS+COL_BITS:0]       o_wr_addr,
    output logic [6:0]                        o_wr_len,
    input  logic                              i_wr_next,
    output logic [15:0]                       o_wr_data,
    output logic                              o_wr_last,
    output logic                              o_buf_sel,
    output logic                              o_frame_done,
    output logic                              o_line_skip,
    output logic                              o_busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // One extra bit so i_x_size + 1 never overflows the word count.
    localparam int WL_BITS = SCR_SIZE_BIT + 2;

    logic [1:0]             state;
    logic [LINE_BITS-1:0]   line_q;
    logic [LINE_BITS-1:0]   expected_q;
    logic [COL_BITS-1:0]    col_q;
    logic [WL_BITS-1:0]     words_left;
    logic [6:0]             burst_cnt;
    logic                   buf_sel_q;
    logic                   skip_q;
    logic                   fifo_reset_d;
    logic [6:0]             len_calc;
    logic                   start;
    logic                   frame_end;
    logic                   unused_y_high;

    assign len_calc  = (words_left >= WL_BITS'(BURST_LEN)) ? 7'(BURST_LEN) : words_left[6:0];
    // NOTE: upstream only drops i_fifo_active on the edge after our reset pulse, so the
    // IDLE cycle right after DONE still sees the consumed line as active and must ignore it.
    assign start     = (state == S_IDLE) && i_fifo_active && !fifo_reset_d;
    assign frame_end = (state == S_DONE) && (line_q == i_y_size[LINE_BITS-1:0]);
    assign unused_y_high = ^i_y_size[SCR_SIZE_BIT:LINE_BITS];

    // NOTE: all state here updates with non-blocking assignments so every branch sees
    // the pre-edge values of the counters it compares against.
    always_ff @(posedge i_ram_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= S_IDLE;
            line_q       <= '0;
            expected_q   <= '0;
            col_q        <= '0;
            words_left   <= '0;
            burst_cnt    <= '0;
            buf_sel_q    <= 1'b0;
            skip_q       <= 1'b0;
            fifo_reset_d <= 1'b0;
        end else begin
            fifo_reset_d <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_REQ;
                        line_q     <= i_fifo_line;
                        words_left <= WL_BITS'(i_x_size) + WL_BITS'(1);
                        col_q      <= '0;
                        if (i_fifo_line != expected_q && i_fifo_line != '0)
                            skip_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (i_wr_gnt) begin
                        burst_cnt <= len_calc;
                        state     <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (i_wr_next) begin
                        burst_cnt  <= burst_cnt - 7'd1;
                        words_left <= words_left - WL_BITS'(1);
                        col_q      <= col_q + COL_BITS'(1);
                        if (burst_cnt == 7'd1)
                            state <= (words_left == WL_BITS'(1)) ? S_DONE : S_REQ;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    if (frame_end) begin
                        buf_sel_q  <= ~buf_sel_q;
                        expected_q <= '0;
                    end else begin
                        expected_q <= line_q + LINE_BITS'(1);
                    end
                end
            endcase
        end
    end

    assign o_wr_req     = (state == S_REQ);
    assign o_wr_addr    = {buf_sel_q, line_q, col_q};
    assign o_wr_len     = (state == S_REQ) ? len_calc : 7'd0;
    assign o_fifo_next  = (state == S_BURST) && i_wr_next;
    assign o_wr_data    = (state == S_BURST) ? {4'h0, i_fifo_data} : 16'h0000;
    assign o_wr_last    = (state == S_BURST) && (burst_cnt == 7'd1);
    assign o_fifo_reset = (state == S_DONE);
    assign o_frame_done = frame_end;
    assign o_buf_sel    = buf_sel_q;
    assign o_line_skip  = skip_q;
    assign o_busy       = (state != S_IDLE);

endmodule
